writeback_stage: RTL and testbench

Final pipeline stage of the CPU core: accepts one retiring instruction per handshake from the memory stage, waits for load data where needed, formats sub-word loads, and drives the register file write port (`waddr`/`wdata`/`wren`/`is_upper`). It also publishes the value being committed as a forwarding source so the decode stage can bypass the register file's same-edge write.

---
 rtl/cpu_wb_pkg.sv | 14 +
 rtl/writeback_stage_load_formatter.sv | 31 +++
 rtl/writeback_stage.sv | 134 +++++++++++++
 tb/tb_writeback_stage.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_wb_pkg.sv
// Shared constants for the writeback stage: load-type codes and FSM state encodings.
package cpu_wb_pkg;

  localparam logic [2:0] LT_LB  = 3'd0;
  localparam logic [2:0] LT_LBU = 3'd1;
  localparam logic [2:0] LT_LH  = 3'd2;
  localparam logic [2:0] LT_LHU = 3'd3;
  localparam logic [2:0] LT_LW  = 3'd4;

  localparam logic [1:0] WB_IDLE     = 2'd0;
  localparam logic [1:0] WB_WAIT_MEM = 2'd1;
  localparam logic [1:0] WB_COMMIT   = 2'd2;

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// Combinational sub-word load extraction: picks the byte/halfword addressed by
// addr_lo from a little-endian word and sign- or zero-extends it to 32 bits.
module load_formatter
  import cpu_wb_pkg::*;
#(
  parameter int LOAD_TYPE_W = 3
) (
  input  logic [LOAD_TYPE_W-1:0] i_load_type,
  input  logic [1:0]             i_addr_lo,
  input  logic [31:0]            i_rdata,
  output logic [31:0]            o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    w_byte = i_rdata[8*i_addr_lo +: 8];
    // Halfword loads only look at addr_lo[1]; a misaligned low bit is ignored.
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    case (i_load_type)
      LT_LB:   o_result = {{24{w_byte[7]}}, w_byte};
      LT_LBU:  o_result = {24'h0, w_byte};
      LT_LH:   o_result = {{16{w_half[15]}}, w_half};
      LT_LHU:  o_result = {16'h0, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: retires one instruction per handshake, waits for load data,
// drives the register-file write port and a registered forwarding copy of the commit.
module writeback_stage
  import cpu_wb_pkg::*;
#(
  parameter int LOAD_TYPE_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_rd,
  input  logic                   in_reg_write,
  input  logic                   in_is_upper,
  input  logic                   in_is_load,
  input  logic [LOAD_TYPE_W-1:0] in_load_type,
  input  logic [1:0]             in_addr_lo,
  input  logic [31:0]            in_alu_result,
  input  logic                   mem_rvalid,
  input  logic [31:0]            mem_rdata,
  output logic [4:0]             rf_waddr,
  output logic [31:0]            rf_wdata,
  output logic                   rf_wren,
  output logic                   rf_is_upper,
  output logic                   fwd_valid,
  output logic [4:0]             fwd_addr,
  output logic [31:0]            fwd_data,
  output logic                   stall
);

  logic [1:0]             r_state;
  logic [4:0]             r_rd;
  logic                   r_reg_write;
  logic                   r_is_upper;
  logic [31:0]            r_wdata;
  logic [LOAD_TYPE_W-1:0] r_load_type;
  logic [1:0]             r_addr_lo;
  logic                   r_wren;
  logic [31:0]            r_fwd_data;

  logic [1:0]             w_next_state;
  logic [4:0]             w_next_rd;
  logic                   w_next_reg_write;
  logic                   w_next_is_upper;
  logic [31:0]            w_next_wdata;
  logic [LOAD_TYPE_W-1:0] w_next_load_type;
  logic [1:0]             w_next_addr_lo;
  logic                   w_next_wren;
  logic [31:0]            w_next_fwd_data;
  logic [31:0]            w_formatted;

  load_formatter #(.LOAD_TYPE_W(LOAD_TYPE_W)) u_load_formatter (
    .i_load_type (r_load_type),
    .i_addr_lo   (r_addr_lo),
    .i_rdata     (mem_rdata),
    .o_result    (w_formatted)
  );

  always_comb begin
    w_next_state     = r_state;
    w_next_rd        = r_rd;
    w_next_reg_write = r_reg_write;
    w_next_is_upper  = r_is_upper;
    w_next_wdata     = r_wdata;
    w_next_load_type = r_load_type;
    w_next_addr_lo   = r_addr_lo;
    case (r_state)
      WB_WAIT_MEM: begin
        if (mem_rvalid) begin
          w_next_state = WB_COMMIT;
          w_next_wdata = w_formatted;
        end
      end
      default: begin
        // IDLE and COMMIT both accept; mem_rvalid is deliberately ignored here.
        if (in_valid) begin
          w_next_rd        = in_rd;
          w_next_reg_write = in_reg_write;
          if (in_is_load) begin
            w_next_state     = WB_WAIT_MEM;
            w_next_load_type = in_load_type;
            w_next_addr_lo   = in_addr_lo;
            w_next_is_upper  = 1'b0;
          end else begin
            w_next_state    = WB_COMMIT;
            w_next_is_upper = in_is_upper;
            w_next_wdata    = in_alu_result;
          end
        end else begin
          w_next_state = WB_IDLE;
        end
      end
    endcase
    // Write enable and forwarded value are precomputed so they leave straight from flops.
    w_next_wren     = (w_next_state == WB_COMMIT) && w_next_reg_write && (w_next_rd != 5'd0);
    w_next_fwd_data = w_next_is_upper ? {w_next_wdata[15:0], 16'h0} : w_next_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= WB_IDLE;
      r_rd        <= '0;
      r_reg_write <= 1'b0;
      r_is_upper  <= 1'b0;
      r_wdata     <= '0;
      r_load_type <= '0;
      r_addr_lo   <= '0;
      r_wren      <= 1'b0;
      r_fwd_data  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      r_state     <= w_next_state;
      r_rd        <= w_next_rd;
      r_reg_write <= w_next_reg_write;
      r_is_upper  <= w_next_is_upper;
      r_wdata     <= w_next_wdata;
      r_load_type <= w_next_load_type;
      r_addr_lo   <= w_next_addr_lo;
      r_wren      <= w_next_wren;
      r_fwd_data  <= w_next_fwd_data;
    end
  end

  assign in_ready    = (r_state != WB_WAIT_MEM);
  assign stall       = (r_state == WB_WAIT_MEM);
  assign rf_waddr    = r_rd;
  assign rf_wdata    = r_wdata;
  assign rf_wren     = r_wren;
  assign rf_is_upper = r_is_upper;
  assign fwd_valid   = r_wren;
  assign fwd_addr    = r_rd;
  assign fwd_data    = r_fwd_data;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: ALU/LUI commits, sub-word loads,
// r0 suppression, back-to-back throughput and reset during an outstanding load.
module tb_writeback_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic        in_is_upper;
  logic        in_is_load;
  logic [2:0]  in_load_type;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_alu_result;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_wren;
  logic        rf_is_upper;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic        stall;

  int n_checks = 0;
  int n_errors = 0;

  writeback_stage #(.LOAD_TYPE_W(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_reg_write  (in_reg_write),
    .in_is_upper   (in_is_upper),
    .in_is_load    (in_is_load),
    .in_load_type  (in_load_type),
    .in_addr_lo    (in_addr_lo),
    .in_alu_result (in_alu_result),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .rf_wren       (rf_wren),
    .rf_is_upper   (rf_is_upper),
    .fwd_valid     (fwd_valid),
    .fwd_addr      (fwd_addr),
    .fwd_data      (fwd_data),
    .stall         (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Outputs depend only on flops, so sampling 1ns after the edge is stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic rw, input logic up, input logic [31:0] val);
    in_valid      = 1'b1;
    in_is_load    = 1'b0;
    in_rd         = rd;
    in_reg_write  = rw;
    in_is_upper   = up;
    in_alu_result = val;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_is_load = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  // Accepts a load (with a stray rvalid in the accept cycle), waits n_wait stall cycles
  // with rvalid in the last one, and leaves the bench sampling the COMMIT cycle.
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] lt,
                         input logic [1:0] lo, input logic [31:0] data, input int n_wait,
                         input logic [31:0] exp);
    in_valid     = 1'b1;
    in_is_load   = 1'b1;
    in_rd        = rd;
    in_reg_write = 1'b1;
    in_is_upper  = 1'b1;
    in_load_type = lt;
    in_addr_lo   = lo;
    mem_rvalid   = 1'b1;
    mem_rdata    = 32'hDEADBEEF;
    tick();
    idle_inputs();
    for (int i = 0; i < n_wait; i++) begin
      check({tag, "_stall"}, {31'b0, stall}, 32'd1);
      check({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
      check({tag, "_wren_wait"}, {31'b0, rf_wren}, 32'd0);
      if (i == n_wait - 1) begin
        mem_rvalid = 1'b1;
        mem_rdata  = data;
      end
      tick();
    end
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;
    check({tag, "_wren"}, {31'b0, rf_wren}, 32'd1);
    check({tag, "_waddr"}, {27'b0, rf_waddr}, {27'b0, rd});
    check({tag, "_wdata"}, rf_wdata, exp);
    check({tag, "_fwd_data"}, fwd_data, exp);
    check({tag, "_is_upper"}, {31'b0, rf_is_upper}, 32'd0);
    check({tag, "_stall_done"}, {31'b0, stall}, 32'd0);
  endtask

  initial begin
    rst_n         = 1'b0;
    in_rd         = '0;
    in_reg_write  = 1'b0;
    in_is_upper   = 1'b0;
    in_load_type  = '0;
    in_addr_lo    = '0;
    in_alu_result = '0;
    mem_rdata     = '0;
    idle_inputs();
    #12;
    check("rst_ready", {31'b0, in_ready}, 32'd1);
    check("rst_wren", {31'b0, rf_wren}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);
    check("rst_wdata", rf_wdata, 32'h0);
    rst_n = 1'b1;
    tick();

    // ADD r5 = 0x12345678, visible the cycle after acceptance.
    drive_alu(5'd5, 1'b1, 1'b0, 32'h12345678);
    tick();
    idle_inputs();
    check("add_wren", {31'b0, rf_wren}, 32'd1);
    check("add_waddr", {27'b0, rf_waddr}, 32'd5);
    check("add_wdata", rf_wdata, 32'h12345678);
    check("add_fwd_valid", {31'b0, fwd_valid}, 32'd1);
    check("add_fwd_addr", {27'b0, fwd_addr}, 32'd5);
    check("add_fwd_data", fwd_data, 32'h12345678);
    tick();
    check("add_idle_wren", {31'b0, rf_wren}, 32'd0);

    // LUI r3: register file sees the raw value, forwarding sees it shifted.
    drive_alu(5'd3, 1'b1, 1'b1, 32'h0000ABCD);
    tick();
    idle_inputs();
    check("lui_wren", {31'b0, rf_wren}, 32'd1);
    check("lui_is_upper", {31'b0, rf_is_upper}, 32'd1);
    check("lui_wdata", rf_wdata, 32'h0000ABCD);
    check("lui_fwd_data", fwd_data, 32'hABCD0000);
    tick();

    do_load("lb", 5'd7, 3'd0, 2'd2, 32'h11802233, 3, 32'hFFFFFF80);
    tick();
    do_load("lbu", 5'd8, 3'd1, 2'd2, 32'h11802233, 3, 32'h00000080);
    // New instruction accepted during the load's COMMIT cycle.
    drive_alu(5'd9, 1'b1, 1'b0, 32'hCAFEF00D);
    tick();
    idle_inputs();
    check("commit_accept_wren", {31'b0, rf_wren}, 32'd1);
    check("commit_accept_waddr", {27'b0, rf_waddr}, 32'd9);
    check("commit_accept_wdata", rf_wdata, 32'hCAFEF00D);
    tick();
    do_load("lhu", 5'd10, 3'd3, 2'd2, 32'h11802233, 3, 32'h00001180);
    tick();
    do_load("lh_odd", 5'd11, 3'd2, 2'd3, 32'h80012233, 1, 32'hFFFF8001);
    tick();
    do_load("lb_b0", 5'd12, 3'd0, 2'd0, 32'h11802273, 2, 32'h00000073);
    tick();
    do_load("lt6_word", 5'd13, 3'd6, 2'd1, 32'h89ABCDEF, 1, 32'h89ABCDEF);
    tick();

    // Write to r0 is suppressed, but the value is still captured through COMMIT.
    drive_alu(5'd0, 1'b1, 1'b0, 32'h55AA55AA);
    tick();
    idle_inputs();
    check("r0_wren", {31'b0, rf_wren}, 32'd0);
    check("r0_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    check("r0_wdata", rf_wdata, 32'h55AA55AA);
    check("r0_ready", {31'b0, in_ready}, 32'd1);
    tick();

    // reg_write=0 to a nonzero register never enables the write port.
    drive_alu(5'd4, 1'b0, 1'b0, 32'h00000001);
    tick();
    idle_inputs();
    check("nowrite_wren", {31'b0, rf_wren}, 32'd0);
    tick();

    // Four back-to-back non-loads at one per cycle.
    for (int i = 0; i < 4; i++) begin
      drive_alu(5'(20 + i), 1'b1, 1'b0, 32'h1000 + 32'(i));
      if (i > 0) begin
        check($sformatf("b2b_ready_%0d", i), {31'b0, in_ready}, 32'd1);
      end
      tick();
      check($sformatf("b2b_wren_%0d", i), {31'b0, rf_wren}, 32'd1);
      check($sformatf("b2b_waddr_%0d", i), {27'b0, rf_waddr}, 32'(20 + i));
      check($sformatf("b2b_wdata_%0d", i), rf_wdata, 32'h1000 + 32'(i));
    end
    idle_inputs();
    check("b2b_last_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("b2b_end_wren", {31'b0, rf_wren}, 32'd0);

    // Reset while a load is outstanding, then a late rvalid must be ignored.
    in_valid     = 1'b1;
    in_is_load   = 1'b1;
    in_rd        = 5'd15;
    in_reg_write = 1'b1;
    in_load_type = 3'd4;
    in_addr_lo   = 2'd0;
    tick();
    idle_inputs();
    tick();
    check("rstw_pre_stall", {31'b0, stall}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstw_async_stall", {31'b0, stall}, 32'd0);
    check("rstw_async_ready", {31'b0, in_ready}, 32'd1);
    check("rstw_async_waddr", {27'b0, rf_waddr}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFFFFFF;
    tick();
    mem_rvalid = 1'b0;
    check("rstw_wren", {31'b0, rf_wren}, 32'd0);
    check("rstw_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    check("rstw_waddr", {27'b0, rf_waddr}, 32'd0);
    check("rstw_wdata", rf_wdata, 32'h0);
    check("rstw_fwd_data", fwd_data, 32'h0);
    check("rstw_fwd_addr", {27'b0, fwd_addr}, 32'd0);
    check("rstw_is_upper", {31'b0, rf_is_upper}, 32'd0);
    check("rstw_stall", {31'b0, stall}, 32'd0);
    check("rstw_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("rstw_late_wren", {31'b0, rf_wren}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
